// File: rtl/pc_irq_pkg.sv
// Shared width helpers and defaults for the program-counter / interrupt controller.
package pc_irq_pkg;

    localparam int unsigned DefAddrW   = 27;
    localparam logic [26:0] DefPcStart = 27'hC02422;

    // Channel-id width; at least one bit so a single-channel build still has a port.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned depth_w(input int unsigned d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of the candidate vector.
module irq_prio_enc import pc_irq_pkg::*; #(
    parameter int unsigned  N   = 4,
    localparam int unsigned IDW = id_w(N)
) (
    input  logic [N-1:0]   cand_i,
    output logic           valid_o,
    output logic [IDW-1:0] id_o
);

    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        // Scan downwards so the lowest index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_i[i]) begin
                valid_o = 1'b1;
                id_o    = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/pc_irq_ctrl.sv
// Program counter with vectored, prioritised, maskable, nestable interrupt entry
// and a return stack for reti.
module pc_irq_ctrl import pc_irq_pkg::*; #(
    parameter int unsigned        ADDR_W     = DefAddrW,
    parameter logic [ADDR_W-1:0]  PC_START   = ADDR_W'(DefPcStart),
    parameter int unsigned        NUM_INT    = 4,
    parameter int unsigned        NEST_DEPTH = 1,
    parameter int unsigned        VEC_BASE   = 1,
    parameter bit                 ROM_GUARD  = 1'b1,
    localparam int unsigned       IDW        = id_w(NUM_INT),
    localparam int unsigned       DW         = depth_w(NEST_DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              step_i,
    input  logic              jump_i,
    input  logic              offset_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              reti_i,
    input  logic [NUM_INT-1:0] irq_i,
    input  logic [NUM_INT-1:0] irq_mask_i,
    output logic [ADDR_W-1:0] pc_out_o,
    output logic              irq_taken_o,
    output logic [IDW-1:0]    irq_id_o,
    output logic [DW-1:0]     int_depth_o,
    output logic [NUM_INT-1:0] pending_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [IDW-1:0]    id;
    } stack_entry_t;

    logic               step_q;
    logic [NUM_INT-1:0] irq_q;
    logic [NUM_INT-1:0] pending_q, pending_d, clr_mask;
    logic [ADDR_W-1:0]  pc_q, pc_d, seq_pc;
    logic [DW-1:0]      depth_q, depth_d;
    logic [IDW-1:0]     id_q, id_d, win_id;
    logic               taken_q, taken_d;
    logic               win_valid, take, push;
    stack_entry_t       stack_q [NEST_DEPTH];
    stack_entry_t       top;

    irq_prio_enc #(
        .N (NUM_INT)
    ) u_prio_enc (
        .cand_i  (pending_q & irq_mask_i),
        .valid_o (win_valid),
        .id_o    (win_id)
    );

    // Entry at depth d-1 is the active handler's return frame.
    always_comb begin
        top = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (DW'(i + 1) == depth_q) top = stack_q[i];
        end
    end

    always_comb begin
        if (!jump_i)       seq_pc = pc_q + ADDR_W'(1);
        else if (offset_i) seq_pc = pc_q + jump_addr_i;
        else               seq_pc = jump_addr_i;
    end

    assign take = win_valid && (depth_q < DW'(NEST_DEPTH))
               && ((depth_q == '0) || (win_id < top.id))
               && (!ROM_GUARD || (pc_q < PC_START));

    always_comb begin
        pc_d     = pc_q;
        depth_d  = depth_q;
        id_d     = id_q;
        taken_d  = 1'b0;
        push     = 1'b0;
        clr_mask = '0;
        if (step_i && !step_q) begin
            if (reti_i) begin
                if (depth_q != '0) begin
                    pc_d    = top.pc;
                    depth_d = depth_q - DW'(1);
                end else begin
                    pc_d = seq_pc;
                end
            end else if (take) begin
                push     = 1'b1;
                pc_d     = ADDR_W'(VEC_BASE) + ADDR_W'(win_id);
                depth_d  = depth_q + DW'(1);
                id_d     = win_id;
                taken_d  = 1'b1;
                clr_mask = NUM_INT'(1) << win_id;
            end else begin
                pc_d = seq_pc;
            end
        end
        // A fresh edge on the channel being taken keeps it pending.
        pending_d = (pending_q & ~clr_mask) | (irq_i & ~irq_q);
    end

    always_ff @(posedge clk_i) begin
        irq_q <= irq_i;
        if (reset_i) begin
            step_q    <= 1'b0;
            pending_q <= '0;
            pc_q      <= PC_START;
            depth_q   <= '0;
            id_q      <= '0;
            taken_q   <= 1'b0;
            for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            step_q    <= step_i;
            pending_q <= pending_d;
            pc_q      <= pc_d;
            depth_q   <= depth_d;
            id_q      <= id_d;
            taken_q   <= taken_d;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (push && (DW'(i) == depth_q)) stack_q[i] <= '{pc: seq_pc, id: win_id};
            end
        end
    end

    assign pc_out_o    = pc_q;
    assign irq_taken_o = taken_q;
    assign irq_id_o    = id_q;
    assign int_depth_o = depth_q;
    assign pending_o   = pending_q;

endmodule

// File: tb/tb_pc_irq_ctrl.sv
// Scoreboard bench: stimulus queues expected state, a monitor compares after each stamped edge.
module tb_pc_irq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Index 0: NEST_DEPTH=1 instance, index 1: NEST_DEPTH=2 instance.
    logic        rst_s   [2];
    logic        step_s  [2];
    logic        jump_s  [2];
    logic        off_s   [2];
    logic [26:0] addr_s  [2];
    logic        reti_s  [2];
    logic [3:0]  irq_s   [2];
    logic [3:0]  mask_s  [2];
    logic [26:0] pc_w    [2];
    logic        tk_w    [2];
    logic [1:0]  id_w    [2];
    logic [3:0]  pend_w  [2];
    logic [0:0]  dep0;
    logic [1:0]  dep1;
    logic [1:0]  dep_w   [2];

    always_comb begin
        dep_w[0] = {1'b0, dep0};
        dep_w[1] = dep1;
    end

    pc_irq_ctrl u_dut0 (
        .clk_i       (clk),
        .reset_i     (rst_s[0]),
        .step_i      (step_s[0]),
        .jump_i      (jump_s[0]),
        .offset_i    (off_s[0]),
        .jump_addr_i (addr_s[0]),
        .reti_i      (reti_s[0]),
        .irq_i       (irq_s[0]),
        .irq_mask_i  (mask_s[0]),
        .pc_out_o    (pc_w[0]),
        .irq_taken_o (tk_w[0]),
        .irq_id_o    (id_w[0]),
        .int_depth_o (dep0),
        .pending_o   (pend_w[0])
    );

    pc_irq_ctrl #(
        .NEST_DEPTH (2)
    ) u_dut1 (
        .clk_i       (clk),
        .reset_i     (rst_s[1]),
        .step_i      (step_s[1]),
        .jump_i      (jump_s[1]),
        .offset_i    (off_s[1]),
        .jump_addr_i (addr_s[1]),
        .reti_i      (reti_s[1]),
        .irq_i       (irq_s[1]),
        .irq_mask_i  (mask_s[1]),
        .pc_out_o    (pc_w[1]),
        .irq_taken_o (tk_w[1]),
        .irq_id_o    (id_w[1]),
        .int_depth_o (dep1),
        .pending_o   (pend_w[1])
    );

    typedef struct {
        int          d;
        int          stamp;
        int          tag;
        logic [26:0] pc;
        logic        tk;
        logic [1:0]  id;
        logic [1:0]  dep;
        logic [3:0]  pend;
    } exp_t;

    exp_t sb[$];
    int   n_tag  = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Monitor: compare every queued expectation whose stamp matches this edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].stamp <= cyc) begin
                exp_t e;
                bit   ok;
                e  = sb.pop_front();
                ok = 1'b1;
                n_chk++;
                if (e.stamp != cyc)        ok = 1'b0;
                if (pc_w[e.d] !== e.pc)    ok = 1'b0;
                if (tk_w[e.d] !== e.tk)    ok = 1'b0;
                if (id_w[e.d] !== e.id)    ok = 1'b0;
                if (dep_w[e.d] !== e.dep)  ok = 1'b0;
                if (pend_w[e.d] !== e.pend) ok = 1'b0;
                if (ok)
                    n_pass++;
                else
                    $display("FAIL chk%0d dut%0d: got pc=%h tk=%b id=%0d dep=%0d pend=%b, want pc=%h tk=%b id=%0d dep=%0d pend=%b",
                             e.tag, e.d, pc_w[e.d], tk_w[e.d], id_w[e.d], dep_w[e.d],
                             pend_w[e.d], e.pc, e.tk, e.id, e.dep, e.pend);
            end
        end
    end

    // Called at a negedge; n is the number of posedges until the state should appear.
    task automatic expect_at(input int d, input int n, input logic [26:0] pc, input logic tk,
                             input logic [1:0] id, input logic [1:0] dep, input logic [3:0] pend);
        exp_t e;
        e.d = d; e.stamp = cyc + n; e.tag = n_tag;
        e.pc = pc; e.tk = tk; e.id = id; e.dep = dep; e.pend = pend;
        sb.push_back(e);
        if (tk) begin
            e.stamp = cyc + n + 1;
            e.tk    = 1'b0;
            sb.push_back(e);
        end
        n_tag++;
    endtask

    task automatic direct_chk(input int d, input logic [26:0] pc, input logic tk);
        n_chk++;
        if (pc_w[d] === pc && tk_w[d] === tk)
            n_pass++;
        else
            $display("FAIL direct dut%0d: got pc=%h tk=%b, want pc=%h tk=%b",
                     d, pc_w[d], tk_w[d], pc, tk);
    endtask

    task automatic do_step(input int d, input logic jmp, input logic off, input logic [26:0] a,
                           input logic rt, input logic [26:0] pc, input logic tk,
                           input logic [1:0] id, input logic [1:0] dep, input logic [3:0] pend);
        jump_s[d] = jmp; off_s[d] = off; addr_s[d] = a; reti_s[d] = rt; step_s[d] = 1'b1;
        expect_at(d, 1, pc, tk, id, dep, pend);
        @(negedge clk);
        direct_chk(d, pc, tk);
        step_s[d] = 1'b0; jump_s[d] = 1'b0; off_s[d] = 1'b0; reti_s[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic inc(input int d, input logic [26:0] pc, input logic [1:0] id,
                       input logic [1:0] dep, input logic [3:0] pend);
        do_step(d, 1'b0, 1'b0, 27'h0, 1'b0, pc, 1'b0, id, dep, pend);
    endtask

    task automatic reti(input int d, input logic [26:0] pc, input logic [1:0] id,
                        input logic [1:0] dep, input logic [3:0] pend);
        do_step(d, 1'b0, 1'b0, 27'h0, 1'b1, pc, 1'b0, id, dep, pend);
    endtask

    task automatic jabs(input int d, input logic [26:0] a, input logic [1:0] id,
                        input logic [1:0] dep);
        do_step(d, 1'b1, 1'b0, a, 1'b0, a, 1'b0, id, dep, 4'b0000);
    endtask

    task automatic irq_set(input int d, input logic [3:0] bits);
        irq_s[d] = irq_s[d] | bits;
        @(negedge clk);
    endtask

    task automatic irq_clr(input int d, input logic [3:0] bits);
        irq_s[d] = irq_s[d] & ~bits;
        @(negedge clk);
    endtask

    task automatic do_reset(input int d);
        rst_s[d] = 1'b1;
        expect_at(d, 1, 27'hC02422, 1'b0, 2'd0, 2'd0, 4'b0000);
        @(negedge clk);
        direct_chk(d, 27'hC02422, 1'b0);
        rst_s[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; step_s[d] = 1'b0; jump_s[d] = 1'b0; off_s[d] = 1'b0;
            addr_s[d] = '0; reti_s[d] = 1'b0; irq_s[d] = '0; mask_s[d] = 4'hF;
        end
        repeat (2) @(negedge clk);

        // NEST_DEPTH=1: sequential PC, ROM guard, reset vs held level.
        do_reset(0);
        inc(0, 27'hC02423, 2'd0, 2'd0, 4'b0000);
        irq_set(0, 4'b0001);
        inc(0, 27'hC02424, 2'd0, 2'd0, 4'b0001);
        inc(0, 27'hC02425, 2'd0, 2'd0, 4'b0001);
        do_reset(0);
        // Step held for three cycles advances once.
        step_s[0] = 1'b1;
        expect_at(0, 3, 27'hC02423, 1'b0, 2'd0, 2'd0, 4'b0000);
        repeat (3) @(negedge clk);
        step_s[0] = 1'b0;
        @(negedge clk);
        irq_clr(0, 4'b0001);

        // Take and return.
        jabs(0, 27'h100, 2'd0, 2'd0);
        irq_set(0, 4'b0100);
        do_step(0, 1'b0, 1'b0, 27'h0, 1'b0, 27'h3, 1'b1, 2'd2, 2'd1, 4'b0000);
        reti(0, 27'h101, 2'd2, 2'd0, 4'b0000);
        irq_clr(0, 4'b0100);

        // Simultaneous requests: priority, no nesting, reti wins over pending.
        jabs(0, 27'h200, 2'd2, 2'd0);
        irq_set(0, 4'b1001);
        do_step(0, 1'b0, 1'b0, 27'h0, 1'b0, 27'h1, 1'b1, 2'd0, 2'd1, 4'b1000);
        reti(0, 27'h201, 2'd0, 2'd0, 4'b1000);
        do_step(0, 1'b0, 1'b0, 27'h0, 1'b0, 27'h4, 1'b1, 2'd3, 2'd1, 4'b0000);
        reti(0, 27'h202, 2'd3, 2'd0, 4'b0000);
        irq_clr(0, 4'b1001);

        // Masked channel stays pending until unmasked.
        mask_s[0] = 4'b1101;
        irq_set(0, 4'b0010);
        inc(0, 27'h203, 2'd3, 2'd0, 4'b0010);
        inc(0, 27'h204, 2'd3, 2'd0, 4'b0010);
        inc(0, 27'h205, 2'd3, 2'd0, 4'b0010);
        mask_s[0] = 4'b1111;
        do_step(0, 1'b0, 1'b0, 27'h0, 1'b0, 27'h2, 1'b1, 2'd1, 2'd1, 4'b0000);
        irq_clr(0, 4'b0010);

        // Relative wrap-around, then reset mid-handler.
        jabs(0, 27'h7FFFFFF, 2'd1, 2'd1);
        do_step(0, 1'b1, 1'b1, 27'h2, 1'b0, 27'h1, 1'b0, 2'd1, 2'd1, 4'b0000);
        do_reset(0);

        // NEST_DEPTH=2: preemption by higher priority only.
        do_reset(1);
        jabs(1, 27'h30, 2'd0, 2'd0);
        irq_set(1, 4'b1000);
        do_step(1, 1'b0, 1'b0, 27'h0, 1'b0, 27'h4, 1'b1, 2'd3, 2'd1, 4'b0000);
        jabs(1, 27'h10, 2'd3, 2'd1);
        irq_set(1, 4'b0010);
        do_step(1, 1'b0, 1'b0, 27'h0, 1'b0, 27'h2, 1'b1, 2'd1, 2'd2, 4'b0000);
        irq_set(1, 4'b0100);
        inc(1, 27'h3, 2'd1, 2'd2, 4'b0100);
        reti(1, 27'h11, 2'd1, 2'd1, 4'b0100);
        reti(1, 27'h31, 2'd1, 2'd0, 4'b0100);
        do_step(1, 1'b0, 1'b0, 27'h0, 1'b0, 27'h3, 1'b1, 2'd2, 2'd1, 4'b0000);
        reti(1, 27'h32, 2'd2, 2'd0, 4'b0000);

        repeat (4) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            $display("FAIL chk%0d dut%0d: expectation never compared, want pc=%h", e.tag, e.d, e.pc);
        end
        if (n_pass == n_chk && n_chk >= 12)
            $display("PASS: %0d/%0d checks passed", n_pass, n_chk);
        else
            $display("FAIL: %0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_irq_ctrl.md
Name: pc_irq_ctrl

Overview:
- Parametrised program-counter unit with a vectored, prioritised, maskable, nestable interrupt controller for the CPU.
- Advances the PC once per execute step and applies jumps, absolute or PC-relative.
- Redirects the PC to a vector on a qualified interrupt and restores the PC from a return stack on reti.
- Sits between the CPU control/writeback stage and instruction fetch.

Parameters:
ADDR_W, 27, PC width; all PC arithmetic is modulo 2^ADDR_W
PC_START, 27'hC02422, reset PC (internal ROM address 0)
NUM_INT, 4, number of interrupt lines (1..16)
NEST_DEPTH, 1, return-stack depth = max nesting level (1..8)
VEC_BASE, 1, vector for channel i = VEC_BASE + i
ROM_GUARD, 1, when 1, interrupts are taken only while pc_out < PC_START

Ports:
clk  in  1  clock, posedge
reset  in  1  reset, synchronous, active-high
step  in  1  writeback strobe; acted on at its rising edge (step & ~step_q)
jump  in  1  current instruction jumps
offset  in  1  jump is relative: pc_out + jump_addr
jump_addr  in  ADDR_W  jump target or offset
reti  in  1  return from interrupt
irq  in  NUM_INT  interrupt request levels; rising edge raises request
irq_mask  in  NUM_INT  1 = channel enabled
pc_out  out  ADDR_W  current PC
irq_taken  out  1  one-cycle pulse when a vector is entered
irq_id  out  IDW  channel of last taken interrupt, IDW = max(1, clog2(NUM_INT))
int_depth  out  clog2(NEST_DEPTH+1)  current nesting level
pending  out  NUM_INT  latched requests

Behaviour:
- Reset:
  - pc_out=PC_START; irq_taken=0; irq_id=0; int_depth=0; pending=0; stack cleared; step_q=0.
  - irq_q loads irq, so levels held across reset never fire.
  - Reset has priority over every other input, including mid-handler: nesting is discarded.
- Edge detect: at each posedge, irq_q<=irq. pending[i] is set when irq[i] & ~irq_q[i].
  - pending[i] is cleared when channel i is taken; a set in the same cycle wins.
  - Masked channels stay pending until unmasked.
- seq_pc:
  - jump=0: pc_out+1.
  - jump=1, offset=1: pc_out+jump_addr.
  - jump=1, offset=0: jump_addr.
  - Truncated to ADDR_W (wrap-around).
- Eligible: cand = pending & irq_mask; winner = lowest set index (fixed priority, 0 highest).
- Take condition: cand!=0 AND int_depth<NEST_DEPTH AND (int_depth==0 OR winner < active id at stack top) AND (!ROM_GUARD OR pc_out<PC_START).
- On each step edge, first match wins:
  1. reti & int_depth>0: pc_out<=stack top PC; pop; int_depth-1.
  2. reti & int_depth==0: treated as a normal step (pc_out<=seq_pc).
  3. take: push {seq_pc, winner}; pc_out<=VEC_BASE+winner; int_depth+1; irq_id<=winner; irq_taken=1 next cycle only; clear pending[winner].
  4. else: pc_out<=seq_pc.
- No step edge: pc_out holds. step held high counts once.
- Latency:
  - pc_out updates at the same posedge where the step edge is sampled.
  - A request is eligible at the first step edge after the cycle in which pending was registered.
- reti and a pending request on the same step: reti wins; the request is taken at the next step if still eligible.
- NEST_DEPTH=1 gives classic behaviour: no preemption; the global enable is implied by int_depth==0.

Decomposition:
- Package pc_irq_pkg: IDW/depth-width functions; stack-entry struct {pc[ADDR_W], id[IDW]}; default PC_START.
- Sub-module irq_prio_enc: combinational lowest-index encoder, (cand) -> (valid, id). Instantiated once.
- Return stack is inline register array plus pointer.

Test Plan:
- Reset, then 3 step pulses, jump=0 -> pc_out 0xC02422, 0xC02423, 0xC02424, 0xC02425. An irq[0] edge here stays pending with no take (ROM_GUARD).
- Absolute jump to 0x100, irq[2] edge, step jump=0 -> pc_out=3, irq_taken pulse, irq_id=2, int_depth=1. Step with reti -> pc_out=0x101, int_depth=0.
- pc_out=0x200, irq[0] and irq[3] edge in the same cycle:
  - step -> pc_out=1 (id 0).
  - reti -> 0x201.
  - step -> pc_out=4, backup 0x202.
  - reti -> 0x202.
- NEST_DEPTH=2, inside channel-3 handler (pc_out=0x10):
  - irq[1] edge, step -> pc_out=2, int_depth=2.
  - irq[2] edge, step -> no take, pc_out=3.
  - reti -> 0x11, then reti -> outer return PC.
  - Next step takes channel 2.
- irq_mask[1]=0, irq[1] edge, 3 steps -> pending[1]=1, sequential PC. Set mask, step -> pc_out=2.
- Wrap and reset: pc_out=0x7FFFFFF, relative jump +2 -> pc_out=0x1. Reset asserted while int_depth=1 -> pc_out=0xC02422, int_depth=0, pending=0.
